pipelined_prefix_subtractor: RTL and testbench

//   Two-stage pipelined N-bit subtractor. Computes d = a - b - bin with a parallel-prefix borrow tree.

---
 rtl/pipelined_prefix_subtractor.sv | 152 +++++++++++++++
 tb/tb_pipelined_prefix_subtractor.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_prefix_subtractor.sv
// pipelined_prefix_subtractor
//   Two-stage pipelined N-bit subtractor, d = a - b - bin, built on a
//   Kogge-Stone borrow tree. Stage 1 holds the operands and the first half
//   of the prefix levels. Stage 2 finishes the tree and forms the difference.
//   Both sides use valid/ready handshakes, and a stall at the output backs up
//   into the input.
//   Optional feature: define OVF_FLAG_EN to add the signed-overflow output ovf
//   together with the sign-bit registers that feed it.
module pipelined_prefix_subtractor #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] d,
  output logic         bout
`ifdef OVF_FLAG_EN
  ,output logic        ovf
`endif
);

  // Prefix tree depth and the number of its levels done in stage 1
  localparam int LV   = $clog2(N);
  localparam int S1LV = (LV + 1) / 2;

  // One Kogge-Stone level. Bits below span keep their G/P unchanged.
  function automatic logic [2*N-1:0] ks_level(input logic [N-1:0] g,
                                              input logic [N-1:0] p,
                                              input int           span);
    logic [N-1:0] gn;
    logic [N-1:0] pn;
    gn = g | (p & (g << span));
    pn = p & ((p << span) | ~({N{1'b1}} << span));
    return {gn, pn};
  endfunction

  logic         s1_valid;
  logic         s2_valid;
  logic         s1_en;
  logic         s2_en;

  logic [N-1:0] s1_a;
  logic [N-1:0] s1_nb;
  logic         s1_cin;
  logic [N-1:0] s1_g;
  logic [N-1:0] s1_p;
`ifdef OVF_FLAG_EN
  logic         s1_sa;
  logic         s1_sb;
  logic         ovf_next;
`endif

  logic [N-1:0] g_s1;
  logic [N-1:0] p_s1;
  logic [N-1:0] g_s2;
  logic [N-1:0] p_s2;
  logic [N:0]   carry;
  logic [N-1:0] d_next;
  logic         bout_next;

  // Ready chain: a stage may load when it is empty or when its content moves on
  always_comb begin
    s2_en    = !s2_valid || out_ready;
    s1_en    = !s1_valid || s2_en;
    in_ready = s1_en;
  end

  assign out_valid = s2_valid;

  // Stage 1 logic: level-0 generate/propagate, then the first prefix levels
  always_comb begin
    g_s1 = a & ~b;
    p_s1 = a | ~b;
    for (int l = 1; l <= S1LV; l++) begin
      {g_s1, p_s1} = ks_level(g_s1, p_s1, 1 << (l - 1));
    end
  end

  // Stage 1 registers. They load on an accepted operation; s1_valid follows in_valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_nb    <= '0;
      s1_cin   <= 1'b0;
      s1_g     <= '0;
      s1_p     <= '0;
`ifdef OVF_FLAG_EN
      s1_sa    <= 1'b0;
      s1_sb    <= 1'b0;
`endif
    end else if (s1_en) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a   <= a;
        s1_nb  <= ~b;
        s1_cin <= ~bin;
        s1_g   <= g_s1;
        s1_p   <= p_s1;
`ifdef OVF_FLAG_EN
        s1_sa  <= a[N-1];
        s1_sb  <= b[N-1];
`endif
      end
    end
  end

  // Stage 2 logic: remaining prefix levels, carries, difference and borrow
  always_comb begin
    g_s2 = s1_g;
    p_s2 = s1_p;
    for (int l = S1LV + 1; l <= LV; l++) begin
      {g_s2, p_s2} = ks_level(g_s2, p_s2, 1 << (l - 1));
    end
    carry     = {g_s2 | (p_s2 & {N{s1_cin}}), s1_cin};
    d_next    = s1_a ^ s1_nb ^ carry[N-1:0];
    bout_next = ~carry[N];
  end

`ifdef OVF_FLAG_EN
  // Signed overflow: the operand signs differ and the result sign differs from a
  assign ovf_next = (s1_sa ^ s1_sb) & (d_next[N-1] ^ s1_sa);
`endif

  // Stage 2 / output registers. They hold while the output is stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      d        <= '0;
      bout     <= 1'b0;
`ifdef OVF_FLAG_EN
      ovf      <= 1'b0;
`endif
    end else if (s2_en) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        d    <= d_next;
        bout <= bout_next;
`ifdef OVF_FLAG_EN
        ovf  <= ovf_next;
`endif
      end
    end
  end

endmodule

// File: tb/tb_pipelined_prefix_subtractor.sv
// tb_pipelined_prefix_subtractor
//   Self-checking bench for pipelined_prefix_subtractor with N=8. Expected
//   results come from plain integer arithmetic held in an in-order queue.
module tb_pipelined_prefix_subtractor;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] d;
  logic         bout;
`ifdef OVF_FLAG_EN
  logic         ovf;
`endif

  pipelined_prefix_subtractor #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bout      (bout)
`ifdef OVF_FLAG_EN
    ,.ovf      (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] d;
    logic         bout;
    logic         ovf;
  } exp_t;

  exp_t         exp_q[$];
  int           checks   = 0;
  int           failures = 0;
  int           n_in     = 0;
  int           n_out    = 0;
  logic         hold_pend = 1'b0;
  logic [N-1:0] hold_d;
  logic         hold_bout;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Reference: integer subtraction, unsigned for borrow, signed for overflow
  function automatic exp_t ref_sub(input logic [N-1:0] ra, input logic [N-1:0] rb, input logic rbin);
    exp_t e;
    int   u;
    int   s;
    u = int'(ra) - int'(rb) - int'(rbin);
    s = int'($signed(ra)) - int'($signed(rb)) - int'(rbin);
    e.d    = u[N-1:0];
    e.bout = (u < 0);
    e.ovf  = (s < -(1 << (N - 1))) || (s > (1 << (N - 1)) - 1);
    return e;
  endfunction

  // One clock cycle, entered and left 1 time unit after a rising edge
  task automatic step(input logic iv, input logic [N-1:0] ia, input logic [N-1:0] ib,
                      input logic ibin, input logic ordy, output logic acc);
    exp_t e;
    in_valid  = iv;
    a         = ia;
    b         = ib;
    bin       = ibin;
    out_ready = ordy;
    #1;
    if (hold_pend) begin
      check("hold_valid", out_valid, 1);
      check("hold_d", d, hold_d);
      check("hold_bout", bout, hold_bout);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", out_valid, 0);
      end else begin
        e = exp_q.pop_front();
        check("d", d, e.d);
        check("bout", bout, e.bout);
`ifdef OVF_FLAG_EN
        check("ovf", ovf, e.ovf);
`endif
        n_out++;
      end
    end
    hold_pend = out_valid && !out_ready;
    hold_d    = d;
    hold_bout = bout;
    acc = iv && in_ready;
    if (acc) begin
      exp_q.push_back(ref_sub(ia, ib, ibin));
      n_in++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    logic acc;
    for (int i = 0; i < budget && exp_q.size() != 0; i++) step(1'b0, '0, '0, 1'b0, 1'b1, acc);
    check("drain_empty", exp_q.size(), 0);
  endtask

  logic [N-1:0] ops_a [4];
  logic [N-1:0] ops_b [4];

  initial begin
    logic acc;
    int   idx;
    int   cyc;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_d", d, 0);
    check("rst_bout", bout, 0);
`ifdef OVF_FLAG_EN
    check("rst_ovf", ovf, 0);
`endif
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Test 1: latency of exactly two clocks, and the result value
    step(1'b1, 8'h05, 8'h03, 1'b0, 1'b1, acc);
    check("t1_acc", acc, 1);
    check("t1_lat1", out_valid, 0);
    step(1'b0, '0, '0, 1'b0, 1'b1, acc);
    check("t1_lat2", out_valid, 1);
    check("t1_d", d, 8'h02);
    drain(4);

    // Tests 2 and 3: wrap, borrow and signed overflow corners
    step(1'b1, 8'h00, 8'h01, 1'b0, 1'b1, acc);
    step(1'b1, 8'h10, 8'h10, 1'b1, 1'b1, acc);
    step(1'b1, 8'h80, 8'h01, 1'b0, 1'b1, acc);
    step(1'b1, 8'h7F, 8'hFF, 1'b0, 1'b1, acc);
    step(1'b1, 8'h80, 8'h00, 1'b1, 1'b1, acc);
    step(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1, acc);
    drain(6);

    // Test 4: four back-to-back ops with out_ready low for three cycles
    ops_a[0] = 8'h01; ops_b[0] = 8'h01;
    ops_a[1] = 8'h09; ops_b[1] = 8'h04;
    ops_a[2] = 8'hFF; ops_b[2] = 8'hFE;
    ops_a[3] = 8'h20; ops_b[3] = 8'h21;
    idx = 0;
    cyc = 0;
    while (idx < 4 && cyc < 20) begin
      if (cyc == 2) begin
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        #1;
        check("t4_full_in_ready", in_ready, 0);
        check("t4_stall_valid", out_valid, 1);
        check("t4_stall_d", d, 8'h00);
      end
      step(1'b1, ops_a[idx], ops_b[idx], 1'b0, (cyc >= 3), acc);
      if (acc) idx++;
      cyc++;
    end
    check("t4_all_accepted", idx, 4);
    drain(8);

    // Test 5: continuous random input, random output backpressure
    n_in  = 0;
    n_out = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, N'($urandom), N'($urandom), 1'($urandom), 1'($urandom), acc);
    end
    drain(40);
    check("t5_count", n_out, n_in);

    // Longer random run with random in_valid gaps
    for (int i = 0; i < 200; i++) begin
      step(1'($urandom_range(0, 3) != 0), N'($urandom), N'($urandom), 1'($urandom),
           1'($urandom_range(0, 3) != 0), acc);
    end
    drain(40);

    // Test 6: asynchronous reset with two ops in flight
    step(1'b1, 8'h33, 8'h11, 1'b0, 1'b0, acc);
    step(1'b1, 8'h44, 8'h22, 1'b0, 1'b0, acc);
    in_valid = 1'b0;
    #2;
    check("t6_pre_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_d", d, 0);
    exp_q.delete();
    hold_pend = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 8'h03, 8'h02, 1'b0, 1'b1, acc);
    check("t6_lat1", out_valid, 0);
    step(1'b0, '0, '0, 1'b0, 1'b1, acc);
    check("t6_lat2", out_valid, 1);
    check("t6_d", d, 8'h01);
    drain(4);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b0, 1'b1, acc);
    check("t6_no_stale", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
